// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard controller beside the decode stage. Drives the
//                enable/clear pins of the PC, IF/ID and ID/EX registers from
//                load-use hazards, reads of a busy multi-cycle mul/div unit,
//                taken-branch flushes and a global memory freeze.
//  Ports       : clk, rst (async, active-low)
//                ID_RsAddr/ID_RtAddr/ID_UsesRs/ID_UsesRt/ID_UsesMD - ID operands
//                EX_MemRead/EX_RtAddr - load in EX; EX_MDStart - mul/div issue
//                Branch_Taken - flush; Mem_Stall - front-end freeze
//                PC_En, IFID_En, IFID_Clr, IDEX_En, IDEX_Clr - register controls
//                MD_Busy - mul/div busy; StallCycles - saturating stall count
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int MD_LATENCY = 32,  // >= 2
    parameter int CNT_W      = 6    // 2**CNT_W must exceed MD_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ID_RsAddr,
    input  logic [4:0]  ID_RtAddr,
    input  logic        ID_UsesRs,
    input  logic        ID_UsesRt,
    input  logic        ID_UsesMD,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_RtAddr,
    input  logic        EX_MDStart,
    input  logic        Branch_Taken,
    input  logic        Mem_Stall,
    output logic        PC_En,
    output logic        IFID_En,
    output logic        IFID_Clr,
    output logic        IDEX_En,
    output logic        IDEX_Clr,
    output logic        MD_Busy,
    output logic [15:0] StallCycles
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] C_LOAD = CNT_W'(MD_LATENCY - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
    localparam logic [15:0]      C_SAT  = 16'hFFFF;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic [15:0]      r_stall_cnt;

    logic w_lu;
    logic w_mds;
    logic w_bubble;

    // Load-use: a load into a non-zero register feeding an operand read in ID.
    assign w_lu = EX_MemRead && (EX_RtAddr != 5'd0) &&
                  ((ID_UsesRs && (ID_RsAddr == EX_RtAddr)) ||
                   (ID_UsesRt && (ID_RtAddr == EX_RtAddr)));

    assign w_mds = (r_state == S_BUSY) && ID_UsesMD;

    // Bubble insertion only when neither the freeze nor a flush takes priority.
    assign w_bubble = rst && !Mem_Stall && !Branch_Taken && (w_lu || w_mds);

    // ------------------------------------------------------------------------
    // Busy FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            S_IDLE: begin
                // A frozen pipeline does not actually issue the op.
                if (EX_MDStart && !Mem_Stall) begin
                    w_state_nxt = S_BUSY;
                    w_count_nxt = C_LOAD;
                end
            end
            S_BUSY: begin
                // The unit keeps computing through a memory freeze; a new
                // start while busy cannot be legal and is ignored.
                w_count_nxt = r_count - C_ONE;
                if (r_count == C_ONE) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_count_nxt = '0;
            end
        endcase
    end

    assign MD_Busy = (r_state == S_BUSY);

    // ------------------------------------------------------------------------
    // Register controls, combinational so they act in the same cycle
    // ------------------------------------------------------------------------
    always_comb begin
        PC_En    = 1'b1;
        IFID_En  = 1'b1;
        IFID_Clr = 1'b0;
        IDEX_En  = 1'b1;
        IDEX_Clr = 1'b0;
        if (!rst) begin
            // hold defaults while in reset regardless of inputs
        end else if (Mem_Stall) begin
            PC_En   = 1'b0;
            IFID_En = 1'b0;
            IDEX_En = 1'b0;
        end else if (Branch_Taken) begin
            // The wrong-path ID instruction is flushed, so its hazards are moot.
            IFID_Clr = 1'b1;
            IDEX_Clr = 1'b1;
        end else if (w_lu || w_mds) begin
            PC_En    = 1'b0;
            IFID_En  = 1'b0;
            IDEX_Clr = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Saturating stall-cycle counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (w_bubble && (r_stall_cnt != C_SAT)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign StallCycles = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl. Directed scenarios plus
//                randomized traffic, all compared against a behavioural model
//                (remaining busy cycles as an integer, stall count as an int).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int MD_LATENCY = 32;
    localparam int CNT_W      = 6;

    logic        clk;
    logic        rst;
    logic [4:0]  ID_RsAddr, ID_RtAddr, EX_RtAddr;
    logic        ID_UsesRs, ID_UsesRt, ID_UsesMD;
    logic        EX_MemRead, EX_MDStart, Branch_Taken, Mem_Stall;
    logic        PC_En, IFID_En, IFID_Clr, IDEX_En, IDEX_Clr, MD_Busy;
    logic [15:0] StallCycles;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int busy_left = 0;  // busy cycles remaining; unit busy while > 0
    int stall_m   = 0;  // expected StallCycles

    hazard_ctrl #(
        .MD_LATENCY (MD_LATENCY),
        .CNT_W      (CNT_W)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .ID_RsAddr    (ID_RsAddr),
        .ID_RtAddr    (ID_RtAddr),
        .ID_UsesRs    (ID_UsesRs),
        .ID_UsesRt    (ID_UsesRt),
        .ID_UsesMD    (ID_UsesMD),
        .EX_MemRead   (EX_MemRead),
        .EX_RtAddr    (EX_RtAddr),
        .EX_MDStart   (EX_MDStart),
        .Branch_Taken (Branch_Taken),
        .Mem_Stall    (Mem_Stall),
        .PC_En        (PC_En),
        .IFID_En      (IFID_En),
        .IFID_Clr     (IFID_Clr),
        .IDEX_En      (IDEX_En),
        .IDEX_Clr     (IDEX_Clr),
        .MD_Busy      (MD_Busy),
        .StallCycles  (StallCycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_lu();
        return EX_MemRead && (EX_RtAddr != 0) &&
               ((ID_UsesRs && ID_RsAddr == EX_RtAddr) ||
                (ID_UsesRt && ID_RtAddr == EX_RtAddr));
    endfunction

    // Expected {PC_En, IFID_En, IFID_Clr, IDEX_En, IDEX_Clr} from the priority rules.
    function automatic logic [4:0] model_ctrl();
        bit hazard;
        hazard = model_lu() || (busy_left > 0 && ID_UsesMD);
        if (!rst)              return 5'b11010;
        else if (Mem_Stall)    return 5'b00000;
        else if (Branch_Taken) return 5'b11111;
        else if (hazard)       return 5'b00011;
        else                   return 5'b11010;
    endfunction

    // Called just after the falling edge with inputs already applied.
    task automatic check_now();
        #1;
        if (!rst) begin
            busy_left = 0;
            stall_m   = 0;
        end
        chk("ctrl", {27'd0, PC_En, IFID_En, IFID_Clr, IDEX_En, IDEX_Clr}, {27'd0, model_ctrl()});
        chk("md_busy", {31'd0, MD_Busy}, {31'd0, (busy_left > 0)});
        chk("stall_cnt", {16'd0, StallCycles}, stall_m);
    endtask

    // Advance across one rising edge, updating the model with the inputs seen there.
    task automatic advance();
        bit bubble;
        @(posedge clk);
        if (!rst) begin
            busy_left = 0;
            stall_m   = 0;
        end else begin
            bubble = !Mem_Stall && !Branch_Taken &&
                     (model_lu() || (busy_left > 0 && ID_UsesMD));
            if (bubble && stall_m < 65535) stall_m++;
            if (busy_left > 0)                 busy_left--;
            else if (EX_MDStart && !Mem_Stall) busy_left = MD_LATENCY - 1;
        end
        @(negedge clk);
    endtask

    task automatic step();
        check_now();
        advance();
    endtask

    task automatic clear_inputs();
        ID_RsAddr = 5'd0; ID_RtAddr = 5'd0; EX_RtAddr = 5'd0;
        ID_UsesRs = 1'b0; ID_UsesRt = 1'b0; ID_UsesMD = 1'b0;
        EX_MemRead = 1'b0; EX_MDStart = 1'b0; Branch_Taken = 1'b0; Mem_Stall = 1'b0;
    endtask

    initial begin
        int cnt;
        int s0;
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        step();
        step();
        rst = 1'b1;

        // Load-use: one-cycle stall, bubble clears the hazard
        EX_MemRead = 1'b1; EX_RtAddr = 5'd5; ID_RsAddr = 5'd5; ID_UsesRs = 1'b1;
        step();
        EX_MemRead = 1'b0;
        step();
        chk("lu_count", {16'd0, StallCycles}, 32'd1);

        // Load to $0 never stalls
        EX_MemRead = 1'b1; EX_RtAddr = 5'd0; ID_RsAddr = 5'd0;
        check_now();
        chk("ld_zero_pc", {31'd0, PC_En}, 32'd1);
        advance();
        clear_inputs();

        // Mul/div busy: issue, then an MD reader stalls for MD_LATENCY-1 cycles
        s0 = stall_m;
        EX_MDStart = 1'b1;
        step();
        EX_MDStart = 1'b0; ID_UsesMD = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            check_now();
            if (PC_En) break;
            cnt++;
            advance();
        end
        chk("md_stall_len", cnt, MD_LATENCY - 1);
        chk("md_busy_end", {31'd0, MD_Busy}, 32'd0);
        chk("md_count", {16'd0, StallCycles}, s0 + MD_LATENCY - 1);
        advance();
        clear_inputs();

        // Branch during load-use: flush wins, counter untouched
        s0 = stall_m;
        EX_MemRead = 1'b1; EX_RtAddr = 5'd7; ID_RtAddr = 5'd7; ID_UsesRt = 1'b1;
        Branch_Taken = 1'b1;
        check_now();
        chk("br_ctrl", {27'd0, PC_En, IFID_En, IFID_Clr, IDEX_En, IDEX_Clr}, 32'b11111);
        advance();
        clear_inputs();
        check_now();
        chk("br_count", {16'd0, StallCycles}, s0);
        advance();

        // Mem_Stall while busy: busy window still lasts MD_LATENCY-1 cycles
        EX_MDStart = 1'b1;
        step();
        EX_MDStart = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            Mem_Stall = (i < 10);
            check_now();
            if (MD_Busy) cnt++;
            advance();
        end
        chk("ms_busy_len", cnt, MD_LATENCY - 1);
        clear_inputs();

        // Reset while busy with 12 cycles remaining
        EX_MDStart = 1'b1;
        step();
        EX_MDStart = 1'b0;
        for (int i = 0; i < MD_LATENCY - 1 - 12; i++) step();
        chk("pre_rst_left", busy_left, 12);
        ID_UsesMD = 1'b1; EX_MemRead = 1'b1; EX_RtAddr = 5'd3; ID_RsAddr = 5'd3; ID_UsesRs = 1'b1;
        rst = 1'b0;
        check_now();
        chk("rst_md_busy", {31'd0, MD_Busy}, 32'd0);
        chk("rst_ctrl", {27'd0, PC_En, IFID_En, IFID_Clr, IDEX_En, IDEX_Clr}, 32'b11010);
        advance();
        step();
        rst = 1'b1;
        clear_inputs();
        step();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 199) != 0);
            ID_RsAddr    = 5'($urandom_range(0, 3));
            ID_RtAddr    = 5'($urandom_range(0, 3));
            EX_RtAddr    = 5'($urandom_range(0, 3));
            ID_UsesRs    = 1'($urandom_range(0, 1));
            ID_UsesRt    = 1'($urandom_range(0, 1));
            ID_UsesMD    = 1'($urandom_range(0, 1));
            EX_MemRead   = ($urandom_range(0, 2) == 0);
            EX_MDStart   = ($urandom_range(0, 15) == 0);
            Branch_Taken = ($urandom_range(0, 9) == 0);
            Mem_Stall    = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
